rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences the shared datapath (PC, IR, register file, ALU, unified memory port) through the fetch, decode, execute, memory and writeback phases.
- Drives ALU_Op to the ALU control decoder, which then produces the 3-bit ALU_Cnt from Opcode, funct3 and funct7.
- Supported opcodes: R-type 51, I-ALU 19, LOAD 3, STORE 35, BRANCH 99, JAL 111, LUI 55.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into the PC on reset (pc_sel=2'd3 selects it).
- MEM_TIMEOUT, 16, cycles to wait for mem_ready before raising bus_err; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Opcode  in  7  IR[6:0], valid from DECODE onward.
- funct3  in  3  IR[14:12], used by BRANCH only (0=BEQ, 1=BNE).
- alu_zero  in  1  ALU zero flag, sampled in EXEC.
- mem_ready  in  1  memory handshake acknowledge.
- mem_req  out  1  memory request; held high until mem_ready.
- mem_we  out  1  write qualifier, valid while mem_req=1.
- iord  out  1  address select: 0=PC (fetch), 1=ALU result (data).
- ir_we  out  1  IR load strobe.
- pc_we  out  1  PC write strobe.
- pc_sel  out  2  PC source: 0=PC+4, 1=branch/jump target, 3=RESET_PC.
- alu_src_a  out  1  ALU operand A: 0=rs1, 1=PC.
- alu_src_b  out  2  ALU operand B: 0=rs2, 1=imm, 2=const 4.
- ALU_Op  out  2  to the ALU control decoder: 0=add, 1=sub/compare, 2=use funct fields.
- rf_we  out  1  register-file write strobe.
- wb_sel  out  2  writeback source: 0=ALU, 1=memory data, 2=PC+4, 3=imm.
- illegal  out  1  sticky flag: unsupported opcode.
- bus_err  out  1  sticky flag: memory timeout.
- state  out  3  current state, for debug.

Behaviour:
- State encoding: RESET=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Reset, while rst=1:
  - state=RESET.
  - All strobes 0; pc_sel=3; illegal=0; bus_err=0; timeout counter=0.
  - The first cycle after rst falls is RESET with pc_we=1, then FETCH.
- rst asserted in any state, including mid memory handshake: mem_req drops the next cycle and no rf_we or pc_we is issued.
- FETCH:
  - mem_req=1, iord=0, mem_we=0.
  - Stay in FETCH until mem_ready=1.
  - In the mem_ready cycle: ir_we=1 and pc_we=1 with pc_sel=0, then go to DECODE.
- DECODE:
  - One cycle; no strobes.
  - alu_src_a=1, alu_src_b=1, ALU_Op=0 (precomputes the branch/jump target).
  - Unsupported opcode: illegal=1, go to HALT.
- EXEC, one cycle, per opcode:
  - R-type: a=0, b=0, ALU_Op=2.
  - I-ALU: a=0, b=1, ALU_Op=2.
  - LOAD/STORE: a=0, b=1, ALU_Op=0.
  - BRANCH: a=0, b=0, ALU_Op=1. Taken when (alu_zero XOR funct3[0]) is 1; if taken, pc_we=1 and pc_sel=1. Next state FETCH.
  - JAL: pc_we=1, pc_sel=1, then WB.
  - LUI: go directly to WB.
- MEM:
  - mem_req=1, iord=1, mem_we=1 for STORE.
  - Wait for mem_ready. STORE then goes to FETCH; LOAD goes to WB.
- WB:
  - rf_we=1 for exactly one cycle; wb_sel per opcode.
  - Next state FETCH.
- Memory handshake:
  - mem_req, mem_we and iord must stay stable from the request until the mem_ready cycle.
  - mem_ready while mem_req=0 is ignored.
- Timeout (MEM_TIMEOUT>0):
  - A counter increments each waiting cycle and clears on mem_ready.
  - If the counter reaches MEM_TIMEOUT: bus_err=1, mem_req drops, go to HALT.
- HALT: absorbing state, all strobes 0; exit only through rst.
- Throughput: R/I/LUI 4 cycles, BRANCH 3, STORE 4, LOAD 5 (each with zero memory wait states).

Optional Feature:
- Macro: RV_CTRL_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt[31:0], reset to 0.
  - Increments by 1 on each instruction completion: WB exit, STORE MEM exit, BRANCH EXEC exit.
  - Wraps from 32'hFFFF_FFFF to 0.
- Undefined: the port does not exist and the counter logic is absent.

Decomposition:
- Package rv_ctrl_pkg:
  - State encodings.
  - Opcode constants (OP_R=7'd51, OP_I=7'd19, OP_LOAD=7'd3, OP_STORE=7'd35, OP_BRANCH=7'd99, OP_JAL=7'd111, OP_LUI=7'd55).
  - ALU_Op, pc_sel and wb_sel encodings.
- Sub-module rv_mem_hs_timer: the handshake wait/timeout counter. Outputs done and timeout.

Test Plan:
- Reset: rst=1 for 3 cycles, then release. Expect one RESET cycle with pc_we=1, pc_sel=3, then FETCH with mem_req=1.
- R-type: Opcode=51, mem_ready=1 immediately. Expect the sequence FETCH, DECODE, EXEC (ALU_Op=2, a=0, b=0), WB (rf_we=1, wb_sel=0), FETCH; 4 cycles total.
- LOAD with 3 wait states: Opcode=3, mem_ready delayed 3 cycles in MEM. Expect iord=1 and mem_we=0 held stable for 4 cycles, then WB with wb_sel=1.
- BRANCH: Opcode=99.
  - funct3=1 with alu_zero=0: pc_we=1, pc_sel=1.
  - funct3=0 with alu_zero=0: no pc_we.
  - Both return to FETCH after 3 cycles.
- Error paths:
  - Opcode=127: illegal=1, state=6, stays in HALT.
  - FETCH with no mem_ready for 16 cycles: bus_err=1, HALT.
  - rst exits HALT in both cases.
- RV_CTRL_RETIRE_CNT_EN: run 5 instructions (R, I, STORE, BRANCH, LOAD). Expect retire_cnt=5.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// ============================================================================
// rv_ctrl_pkg: states, opcodes and control encodings for rv_multicycle_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_I      = 7'd19;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_LUI    = 7'd55;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_RESET  = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_LUI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_multicycle_ctrl_timer.sv
// ============================================================================
// rv_mem_hs_timer: memory handshake completion and wait-state timeout.
// Rev 1.0
// ============================================================================
`default_nettype none

module rv_mem_hs_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_ready,
  output logic o_done,
  output logic o_timeout
);

  assign o_done = i_req & i_ready;

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      localparam int CW = $clog2(MEM_TIMEOUT + 1);
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst || !i_req || i_ready) r_cnt <= '0;
        else                          r_cnt <= r_cnt + 1'b1;
      end

      // Fires on the MEM_TIMEOUT-th consecutive cycle without an acknowledge.
      assign o_timeout = i_req & ~i_ready & (r_cnt == CW'(MEM_TIMEOUT - 1));
    end else begin : g_no_timeout
      logic w_unused_timer;
      assign w_unused_timer = clk ^ rst;
      assign o_timeout      = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/rv_multicycle_ctrl.sv
// ============================================================================
// rv_multicycle_ctrl: main control FSM of the multi-cycle RV32I core.
// Optional macro RV_CTRL_RETIRE_CNT_EN adds the retire_cnt output. Rev 1.0
// ============================================================================
`default_nettype none

module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  Opcode,
  input  logic [2:0]  funct3,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  ALU_Op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        bus_err,
`ifdef RV_CTRL_RETIRE_CNT_EN
  output logic [31:0] retire_cnt,
`endif
  output logic [2:0]  state
);

  // The reset vector itself is muxed in by the datapath on pc_sel=PC_RESET.
  localparam logic [31:0] c_unused_reset_pc = RESET_PC;

  state_t r_state, w_next;
  logic   r_illegal, r_bus_err;
  logic   w_set_illegal, w_set_bus_err;
  logic   w_wait, w_done, w_timeout;
  logic   w_unused_funct3;

  assign w_unused_funct3 = ^funct3[2:1];
  assign w_wait = !rst && ((r_state == ST_FETCH) || (r_state == ST_MEM));

  rv_mem_hs_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_wait),
    .i_ready   (mem_ready),
    .o_done    (w_done),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RESET;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_bus_err) r_bus_err <= 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = PC_PLUS4;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    ALU_Op        = ALU_ADD;
    rf_we         = 1'b0;
    wb_sel        = WB_ALU;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    case (r_state)
      ST_RESET: begin
        pc_sel = PC_RESET;
        pc_we  = 1'b1;
        w_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (w_timeout) begin
          w_set_bus_err = 1'b1;
          w_next        = ST_HALT;
        end else if (w_done) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // PC + imm is formed here so branches and JAL have their target ready.
        alu_src_a = 1'b1;
        alu_src_b = 2'd1;
        if (op_supported(Opcode)) begin
          w_next = ST_EXEC;
        end else begin
          w_set_illegal = 1'b1;
          w_next        = ST_HALT;
        end
      end
      ST_EXEC: begin
        case (Opcode)
          OP_R: begin
            ALU_Op = ALU_FUNCT;
            w_next = ST_WB;
          end
          OP_I: begin
            alu_src_b = 2'd1;
            ALU_Op    = ALU_FUNCT;
            w_next    = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b = 2'd1;
            w_next    = ST_MEM;
          end
          OP_BRANCH: begin
            ALU_Op = ALU_SUB;
            if (alu_zero ^ funct3[0]) begin
              pc_we  = 1'b1;
              pc_sel = PC_TARGET;
            end
            w_next = ST_FETCH;
          end
          OP_JAL: begin
            pc_we  = 1'b1;
            pc_sel = PC_TARGET;
            w_next = ST_WB;
          end
          OP_LUI:  w_next = ST_WB;
          default: begin
            w_set_illegal = 1'b1;
            w_next        = ST_HALT;
          end
        endcase
      end
      ST_MEM: begin
        alu_src_b = 2'd1;
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_we    = (Opcode == OP_STORE);
        if (w_timeout) begin
          w_set_bus_err = 1'b1;
          w_next        = ST_HALT;
        end else if (w_done) begin
          w_next = (Opcode == OP_STORE) ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        rf_we = 1'b1;
        case (Opcode)
          OP_LOAD: wb_sel = WB_MEM;
          OP_JAL:  wb_sel = WB_PC4;
          OP_LUI:  wb_sel = WB_IMM;
          default: wb_sel = WB_ALU;
        endcase
        w_next = ST_FETCH;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_RESET;
    endcase
    // Reset wins over any handshake in flight: nothing may commit this cycle.
    if (rst) begin
      w_next        = ST_RESET;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      rf_we         = 1'b0;
      pc_sel        = PC_RESET;
      w_set_illegal = 1'b0;
      w_set_bus_err = 1'b0;
    end
  end

`ifdef RV_CTRL_RETIRE_CNT_EN
  logic        w_retire;
  logic [31:0] r_retire_cnt;

  assign w_retire = !rst && ((r_state == ST_WB) ||
                    ((r_state == ST_MEM) && (Opcode == OP_STORE) && w_done && !w_timeout) ||
                    ((r_state == ST_EXEC) && (Opcode == OP_BRANCH)));

  always_ff @(posedge clk) begin
    if (rst)           r_retire_cnt <= 32'd0;
    else if (w_retire) r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  assign retire_cnt = r_retire_cnt;
`endif

  assign illegal = r_illegal;
  assign bus_err = r_bus_err;
  assign state   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
// ============================================================================
// tb_rv_multicycle_ctrl: scoreboard bench for rv_multicycle_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rv_multicycle_ctrl;

  localparam logic [2:0] S_RESET = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;
  localparam logic [6:0] R = 7'd51, I = 7'd19, LD = 7'd3, ST = 7'd35,
                         BR = 7'd99, JAL = 7'd111, LUI = 7'd55;

  logic        clk = 1'b0, rst = 1'b1;
  logic [6:0]  Opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        alu_zero = 1'b0, mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_we, pc_we, alu_src_a, rf_we, illegal, bus_err;
  logic [1:0]  pc_sel, alu_src_b, ALU_Op, wb_sel;
  logic [2:0]  state;
`ifdef RV_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  rv_multicycle_ctrl #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .funct3(funct3), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ALU_Op(ALU_Op), .rf_we(rf_we), .wb_sel(wb_sel),
    .illegal(illegal), .bus_err(bus_err),
`ifdef RV_CTRL_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    int unsigned c;
    logic [2:0]  st;
    logic        mreq, iord, mwe, irwe, pcwe;
    logic [1:0]  pcsel;
    logic        rfwe;
    logic [1:0]  wbsel;
    logic        chk_alu, a;
    logic [1:0]  b, op;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0, n_pass = 0;
  bit  mon_en = 1'b0;
  int  n_instr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void push(input int unsigned c, input logic [2:0] st, input logic mreq,
                               input logic mwe, input logic irwe, input logic pcwe,
                               input logic [1:0] pcsel, input logic rfwe, input logic [1:0] wbsel,
                               input logic chk, input logic a, input logic [1:0] b,
                               input logic [1:0] op);
    ev_t e;
    e.c = c; e.st = st; e.mreq = mreq; e.iord = (st == S_MEM); e.mwe = mwe;
    e.irwe = irwe; e.pcwe = pcwe; e.pcsel = pcsel; e.rfwe = rfwe; e.wbsel = wbsel;
    e.chk_alu = chk; e.a = a; e.b = b; e.op = op;
    exp_q.push_back(e);
  endfunction

  // Monitor: any strobe, any memory request, or a DECODE/EXEC cycle is an event.
  always @(negedge clk) begin : monitor
    ev_t e;
    bit  ok;
    if (mon_en && (mem_req || pc_we || rf_we || ir_we || state == S_DECODE || state == S_EXEC)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: cycle %0d state %0d, nothing expected", cyc, state);
      end else begin
        e  = exp_q.pop_front();
        ok = (cyc == e.c) && (state == e.st) && (mem_req == e.mreq) && (ir_we == e.irwe) &&
             (pc_we == e.pcwe) && (rf_we == e.rfwe);
        if (e.mreq)    ok = ok && (iord == e.iord) && (mem_we == e.mwe);
        if (e.pcwe)    ok = ok && (pc_sel == e.pcsel);
        if (e.rfwe)    ok = ok && (wb_sel == e.wbsel);
        if (e.chk_alu) ok = ok && (alu_src_a == e.a) && (alu_src_b == e.b) && (ALU_Op == e.op);
        if (ok) n_pass++;
        else $display("FAIL event: got cyc=%0d st=%0d req=%b iord=%b we=%b ir=%b pc=%b/%0d rf=%b/%0d alu=%b/%0d/%0d required cyc=%0d st=%0d req=%b iord=%b we=%b ir=%b pc=%b/%0d rf=%b/%0d alu=%b/%0d/%0d",
                      cyc, state, mem_req, iord, mem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
                      alu_src_a, alu_src_b, ALU_Op, e.c, e.st, e.mreq, e.iord, e.mwe, e.irwe,
                      e.pcwe, e.pcsel, e.rfwe, e.wbsel, e.a, e.b, e.op);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the edge that starts the instruction's first FETCH cycle.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic az,
                           input int wf, input int wm);
    int unsigned t0, e;
    logic taken;
    t0 = cyc;
    Opcode = op; funct3 = f3; alu_zero = az;
    for (int i = 0; i <= wf; i++)
      push(t0 + i, S_FETCH, 1, 0, i == wf, i == wf, 2'd0, 0, 2'd0, 0, 0, 2'd0, 2'd0);
    push(t0 + wf + 1, S_DECODE, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 1, 2'd1, 2'd0);
    e = t0 + wf + 2;
    case (op)
      R: begin
        push(e, S_EXEC, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 0, 2'd0, 2'd2);
        push(e + 1, S_WB, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0, 0, 2'd0, 2'd0);
      end
      I: begin
        push(e, S_EXEC, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 0, 2'd1, 2'd2);
        push(e + 1, S_WB, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0, 0, 2'd0, 2'd0);
      end
      LUI: begin
        push(e, S_EXEC, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 2'd0, 2'd0);
        push(e + 1, S_WB, 0, 0, 0, 0, 2'd0, 1, 2'd3, 0, 0, 2'd0, 2'd0);
      end
      JAL: begin
        push(e, S_EXEC, 0, 0, 0, 1, 2'd1, 0, 2'd0, 0, 0, 2'd0, 2'd0);
        push(e + 1, S_WB, 0, 0, 0, 0, 2'd0, 1, 2'd2, 0, 0, 2'd0, 2'd0);
      end
      BR: begin
        taken = az ^ f3[0];
        push(e, S_EXEC, 0, 0, 0, taken, 2'd1, 0, 2'd0, 1, 0, 2'd0, 2'd1);
      end
      default: begin
        push(e, S_EXEC, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 0, 2'd1, 2'd0);
        for (int i = 0; i <= wm; i++)
          push(e + 1 + i, S_MEM, 1, op == ST, 0, 0, 2'd0, 0, 2'd0, 0, 0, 2'd0, 2'd0);
        if (op == LD)
          push(e + 2 + wm, S_WB, 0, 0, 0, 0, 2'd0, 1, 2'd1, 0, 0, 2'd0, 2'd0);
      end
    endcase
    for (int i = 0; i <= wf; i++) begin mem_ready = (i == wf); step(); end
    mem_ready = 1'($urandom); step();
    mem_ready = 1'($urandom); step();
    if (op == LD || op == ST)
      for (int i = 0; i <= wm; i++) begin mem_ready = (i == wm); step(); end
    if (op != ST && op != BR) begin mem_ready = 1'($urandom); step(); end
    n_instr++;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0;
    repeat (3) step();
    check("reset_outputs", {state, pc_sel, mem_req, ir_we, pc_we, rf_we, illegal, bus_err},
          {S_RESET, 2'd3, 6'b0});
`ifdef RV_CTRL_RETIRE_CNT_EN
    check("reset_retire_cnt", retire_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_exit_cycle", {state, pc_we, pc_sel}, {S_RESET, 1'b1, 2'd3});
    step();
    check("first_fetch", {state, mem_req, iord, mem_we}, {S_FETCH, 3'b100});
    n_instr = 0;
  endtask

  logic [6:0] ops [7] = '{R, I, LD, ST, BR, JAL, LUI};

  initial begin
    logic [6:0] op;
    do_reset();
    mon_en = 1'b1;
    run_instr(R, 3'd0, 0, 0, 0);
    run_instr(I, 3'd5, 0, 1, 0);
    run_instr(ST, 3'd2, 0, 0, 0);
    run_instr(BR, 3'd1, 0, 0, 0);
    run_instr(LD, 3'd2, 0, 0, 3);
`ifdef RV_CTRL_RETIRE_CNT_EN
    check("retire_cnt_5", retire_cnt, 5);
`endif
    run_instr(BR, 3'd0, 0, 0, 0);
    for (int k = 0; k < 150; k++) begin
      op = ops[$urandom_range(0, 6)];
      run_instr(op, (op == BR) ? 3'($urandom_range(0, 1)) : 3'($urandom),
                1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    mon_en = 1'b0;
    check("scoreboard_drained", 64'(exp_q.size()), 0);
`ifdef RV_CTRL_RETIRE_CNT_EN
    check("retire_cnt_total", retire_cnt, 64'(n_instr));
`endif

    // Reset landing on an acknowledged fetch must not commit anything.
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    check("rst_mid_handshake", {mem_req, ir_we, pc_we, rf_we}, 0);
    do_reset();

    Opcode = 7'd127; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    #1;
    check("illegal_decode", {state, illegal}, {S_DECODE, 1'b0});
    step();
    check("illegal_halt", {state, illegal}, {S_HALT, 1'b1});
    for (int k = 0; k < 4; k++) begin
      mem_ready = 1'($urandom);
      step();
      check("illegal_absorb", {state, mem_req, ir_we, pc_we, rf_we, illegal, bus_err},
            {S_HALT, 4'b0, 1'b1, 1'b0});
    end
    do_reset();

    Opcode = R; mem_ready = 1'b0;
    repeat (15) step();
    check("timeout_wait16", {state, mem_req, bus_err}, {S_FETCH, 1'b1, 1'b0});
    step();
    check("timeout_halt", {state, mem_req, bus_err}, {S_HALT, 1'b0, 1'b1});
    mem_ready = 1'b1;
    repeat (2) step();
    check("timeout_absorb", {state, mem_req, ir_we, pc_we, rf_we, bus_err},
          {S_HALT, 4'b0, 1'b1});
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
